foc_sample_frontend: RTL and testbench
======================================

# foc_sample_frontend

Acquisition front end for the FOC current loop. On each PWM-period trigger it captures the resolver angle, then reads the phase-current channels from an external 12-bit serial ADC as an SPI master. It converts each offset-binary sample to signed Q-format and presents one frame on a valid/ready handshake to the FOC controller's `valid`/`ready` inputs. It is the producer end of the controller's input interface.

## Interface
- `D_WIDTH`, 16: output data width.
- `ADC_BITS`, 12: ADC result width.
- `CURR_SHIFT`, 2: left shift applied after offset removal.
- `SCLK_DIV`, 4: clk cycles per SCLK half-period; must be ≥ 1.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `trigger` in 1: one-cycle pulse at PWM period start.
- `angle_in` in 16: resolver angle.
- `adc_miso` in 1: ADC serial data.
- `adc_sclk` out 1: SPI clock, CPOL=0.
- `adc_csn` out 1: ADC chip select, active low.
- `adc_mosi` out 1: channel address bits.
- `ctrl_ready` in 1: controller ready.
- `valid_out` out 1: frame valid.
- `angle_out` out 16: latched angle.
- `currA_out`, `currB_out`, `currC_out` out D_WIDTH each: signed phase currents.
- `busy` out 1: acquisition in progress.
- `overrun_cnt` out 8: dropped-trigger count, saturating.

## Operation
- States: IDLE, CS_SETUP, SHIFT, CS_GAP, PRESENT.
- IDLE:
  - `trigger`=1 latches `angle_in` into `angle_out`, sets channel index to 0 and moves to CS_SETUP.
  - `busy` is 1 in every state except IDLE.
- CS_SETUP: `adc_csn`=0 for 1 cycle, then SHIFT.
- SHIFT: 16 SCLK periods.
  - SCLK is low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - MOSI changes while SCLK is low: bits 15..14 = channel index (MSB first); remaining bits are 0.
  - MISO is sampled on the clk that raises SCLK. SCLK periods 5..16 deliver result bits 11..0 of the current channel.
- CS_GAP: `adc_csn`=1, `adc_sclk`=0 for 2 cycles.
  - Stores the converted sample.
  - Moves to CS_SETUP for the next channel, or to PRESENT after the last channel.
- Conversion: out = sign_extend(raw − 2^(ADC_BITS−1)) <<< CURR_SHIFT, D_WIDTH wide, no saturation. With defaults, the range is −8192..+8188.
- PRESENT: `valid_out`=1. All outputs are held stable until the cycle with `valid_out && ctrl_ready`; the next state is IDLE with `valid_out`=0.
- Triggers are accepted only in IDLE.
  - A trigger in any other state, including the handshake cycle, is dropped and increments `overrun_cnt`, saturating at 255.
  - Output registers change only at frame completion, never mid-acquisition.
- Reset: all outputs are 0 except `adc_csn`=1. State goes to IDLE and `overrun_cnt` to 0.
- Reset mid-frame aborts the transfer immediately: CS high, SCLK low, no partial frame presented.

## Timing
- Per channel: 3 + 32·SCLK_DIV cycles (131 at default).
- `valid_out` rises N·(3+32·SCLK_DIV)+1 cycles after the trigger cycle, where N is the number of channels converted: 394 (N=3) or 263 (N=2, macro set) at default.
- `ctrl_ready` high when `valid_out` rises gives a 1-cycle handshake.
- Minimum trigger spacing without overrun = latency + 1.
- SCLK frequency = clk/(2·SCLK_DIV).

## Configuration
- `FOC_FRONTEND_CALC_C_EN` defined:
  - Only channels 0 (A) and 1 (B) are converted.
  - `currC_out` = −currA_out − currB_out, truncated to D_WIDTH, registered together with A/B.
- `FOC_FRONTEND_CALC_C_EN` undefined: channels 0, 1, 2 are converted, and C is measured.

## Test plan
- Reset: assert `rst` 2 cycles → `adc_csn`=1, `adc_sclk`=0, `valid_out`=0, `busy`=0, `overrun_cnt`=0, all data 0.
- Frame, macro off: trigger with `angle_in`=0x1234; ADC model returns 0x800, 0xFFF, 0x000 → at cycle 394 `valid_out`=1, angle 0x1234, A=0, B=8188, C=−8192. MOSI channel fields read 0, 1, 2.
- Macro on: ADC returns 0x900, 0x700 → at cycle 263 A=1024, B=−1024, C=0; only 2 CS frames observed.
- Backpressure: hold `ctrl_ready`=0 for 50 cycles after valid → outputs stable, then one-cycle handshake drops `valid_out` next cycle.
- Overrun: 3 triggers during SHIFT plus 1 in the handshake cycle → `overrun_cnt`=4, frame data unaffected; 300 triggers → saturates at 255.
- Mid-frame reset: assert `rst` at cycle 100 → next cycle `adc_csn`=1, `busy`=0, no `valid_out`; a new trigger yields a correct complete frame.

Source files
------------

// File: rtl/foc_sample_frontend.sv
// rtl/foc_sample_frontend.sv - FOC acquisition front end: angle latch, SPI ADC reader, Q-format currents; optional macro FOC_FRONTEND_CALC_C_EN
module foc_sample_frontend #(
    parameter int D_WIDTH    = 16,
    parameter int ADC_BITS   = 12,
    parameter int CURR_SHIFT = 2,
    parameter int SCLK_DIV   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic [15:0]        angle_in,
    input  logic               adc_miso,
    output logic               adc_sclk,
    output logic               adc_csn,
    output logic               adc_mosi,
    input  logic               ctrl_ready,
    output logic               valid_out,
    output logic [15:0]        angle_out,
    output logic [D_WIDTH-1:0] currA_out,
    output logic [D_WIDTH-1:0] currB_out,
    output logic [D_WIDTH-1:0] currC_out,
    output logic               busy,
    output logic [7:0]         overrun_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CS_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_CS_GAP   = 3'd3;
    localparam logic [2:0] S_PRESENT  = 3'd4;

`ifdef FOC_FRONTEND_CALC_C_EN
    // Phase C is reconstructed, so only A and B are read from the ADC
    localparam logic [1:0] LAST_CH = 2'd1;
`else
    localparam logic [1:0] LAST_CH = 2'd2;
`endif

    localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    logic [2:0]                r_state;
    logic [DIV_W-1:0]          r_div;
    logic [3:0]                r_bit;
    logic [1:0]                r_ch;
    logic                      r_gap;
    logic [ADC_BITS-1:0]       r_shreg;
    logic [D_WIDTH-1:0]        r_hold_a;
    logic [D_WIDTH-1:0]        r_hold_b;
`ifdef FOC_FRONTEND_CALC_C_EN
`else
    logic [D_WIDTH-1:0]        r_hold_c;
`endif
    logic                      r_sclk;
    logic                      r_csn;
    logic                      r_mosi;
    logic                      r_valid;
    logic [15:0]               r_angle;
    logic [D_WIDTH-1:0]        r_curr_a;
    logic [D_WIDTH-1:0]        r_curr_b;
    logic [D_WIDTH-1:0]        r_curr_c;
    logic [7:0]                r_overrun;

    // Offset binary to two's complement is an MSB flip; then sign-extend and scale
    logic [ADC_BITS-1:0]       w_tc;
    logic signed [D_WIDTH-1:0] w_ext;
    logic [D_WIDTH-1:0]        w_conv;
    logic [1:0]                w_next_ch;

    assign w_tc      = {~r_shreg[ADC_BITS-1], r_shreg[ADC_BITS-2:0]};
    assign w_ext     = {{(D_WIDTH-ADC_BITS){w_tc[ADC_BITS-1]}}, w_tc};
    assign w_conv    = w_ext <<< CURR_SHIFT;
    assign w_next_ch = r_ch + 2'd1;

    // Acquisition sequencer: SPI framing, sample capture and frame presentation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_ch     <= '0;
            r_gap    <= 1'b0;
            r_shreg  <= '0;
            r_hold_a <= '0;
            r_hold_b <= '0;
`ifdef FOC_FRONTEND_CALC_C_EN
`else
            r_hold_c <= '0;
`endif
            r_sclk   <= 1'b0;
            r_csn    <= 1'b1;
            r_mosi   <= 1'b0;
            r_valid  <= 1'b0;
            r_angle  <= '0;
            r_curr_a <= '0;
            r_curr_b <= '0;
            r_curr_c <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        r_angle <= angle_in;
                        r_ch    <= 2'd0;
                        r_csn   <= 1'b0;
                        r_mosi  <= 1'b0;
                        r_state <= S_CS_SETUP;
                    end
                end
                S_CS_SETUP: begin
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_sclk  <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            // Rising SCLK: ADC data is already stable, sample it now
                            r_sclk  <= 1'b1;
                            r_shreg <= {r_shreg[ADC_BITS-2:0], adc_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == 4'd15) begin
                                r_csn   <= 1'b1;
                                r_mosi  <= 1'b0;
                                r_gap   <= 1'b0;
                                r_state <= S_CS_GAP;
                            end else begin
                                // Address word is {ch[1:0], 14'b0}, MSB first
                                r_bit  <= r_bit + 4'd1;
                                r_mosi <= (r_bit == 4'd0) ? r_ch[0] : 1'b0;
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_CS_GAP: begin
                    if (!r_gap) begin
                        r_gap <= 1'b1;
                        if (r_ch == 2'd0) begin
                            r_hold_a <= w_conv;
                        end else if (r_ch == 2'd1) begin
                            r_hold_b <= w_conv;
                        end else begin
`ifdef FOC_FRONTEND_CALC_C_EN
`else
                            r_hold_c <= w_conv;
`endif
                        end
                    end else if (r_ch == LAST_CH) begin
                        // Outputs are only updated here, as one coherent frame
                        r_curr_a <= r_hold_a;
                        r_curr_b <= r_hold_b;
`ifdef FOC_FRONTEND_CALC_C_EN
                        r_curr_c <= -r_hold_a - r_hold_b;
`else
                        r_curr_c <= r_hold_c;
`endif
                        r_valid  <= 1'b1;
                        r_state  <= S_PRESENT;
                    end else begin
                        r_ch    <= w_next_ch;
                        r_csn   <= 1'b0;
                        r_mosi  <= w_next_ch[1];
                        r_state <= S_CS_SETUP;
                    end
                end
                S_PRESENT: begin
                    if (ctrl_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Triggers outside IDLE are dropped and counted, saturating at 255
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= '0;
        end else if (trigger && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign adc_sclk    = r_sclk;
    assign adc_csn     = r_csn;
    assign adc_mosi    = r_mosi;
    assign valid_out   = r_valid;
    assign angle_out   = r_angle;
    assign currA_out   = r_curr_a;
    assign currB_out   = r_curr_b;
    assign currC_out   = r_curr_c;
    assign busy        = (r_state != S_IDLE);
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_foc_sample_frontend.sv
// tb/tb_foc_sample_frontend.sv - directed-vector bench for foc_sample_frontend with a channel-addressed SPI ADC model
`timescale 1ns/1ps
module tb_foc_sample_frontend;

`ifdef FOC_FRONTEND_CALC_C_EN
    localparam int NCH = 2;
    localparam int LAT = 263;
`else
    localparam int NCH = 3;
    localparam int LAT = 394;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic [15:0] angle_in;
    logic        adc_miso;
    logic        adc_sclk;
    logic        adc_csn;
    logic        adc_mosi;
    logic        ctrl_ready;
    logic        valid_out;
    logic [15:0] angle_out;
    logic [15:0] curr_a;
    logic [15:0] curr_b;
    logic [15:0] curr_c;
    logic        busy;
    logic [7:0]  overrun_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] adc_raw [0:3];
    int          rises = 0;
    logic [1:0]  ch_bits = 2'd0;
    int          ch_log[$];
    int          cs_frames = 0;
    int          sclk_total = 0;

    always #5 clk = ~clk;

    foc_sample_frontend dut (
        .clk(clk), .rst(rst), .trigger(trigger), .angle_in(angle_in),
        .adc_miso(adc_miso), .adc_sclk(adc_sclk), .adc_csn(adc_csn), .adc_mosi(adc_mosi),
        .ctrl_ready(ctrl_ready), .valid_out(valid_out), .angle_out(angle_out),
        .currA_out(curr_a), .currB_out(curr_b), .currC_out(curr_c),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    // ADC model: CS fall starts a frame, address taken from first two MOSI bits
    always @(negedge adc_csn or posedge adc_sclk) begin
        if (adc_sclk) begin
            if (rises < 2) ch_bits = {ch_bits[0], adc_mosi};
            rises = rises + 1;
            sclk_total = sclk_total + 1;
            if (rises == 2) ch_log.push_back(int'(ch_bits));
        end else begin
            rises = 0;
            ch_bits = 2'd0;
            cs_frames = cs_frames + 1;
        end
    end

    // Result bits 11..0 are presented for SCLK periods 5..16
    always_comb begin
        adc_miso = 1'b0;
        if (rises >= 4 && rises < 16) adc_miso = adc_raw[ch_bits][15 - rises];
    end

    task automatic start_frame(input logic [15:0] ang, input logic [11:0] r0, input logic [11:0] r1,
                               input logic [11:0] r2, input int extra);
        adc_raw[0] = r0;
        adc_raw[1] = r1;
        adc_raw[2] = r2;
        adc_raw[3] = 12'h000;
        @(negedge clk);
        angle_in = ang;
        trigger  = 1'b1;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            angle_in = ~ang;
            trigger  = (c == 10 && extra >= 1) || (c == 20 && extra >= 2) || (c == 30 && extra >= 3);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (adc_csn !== 1'b1) begin n_err++; $display("FAIL reset_csn: got %b want 1", adc_csn); end
        n_vec++; if (adc_sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", adc_sclk); end
        n_vec++; if (adc_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", adc_mosi); end
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
        n_vec++;
        if ({angle_out, curr_a, curr_b, curr_c} !== 64'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {angle_out, curr_a, curr_b, curr_c});
        end
        rst = 1'b0;
    endtask

    task automatic test_frame;
        logic [15:0] ea, eb, ec;
        int f0, s0;
`ifdef FOC_FRONTEND_CALC_C_EN
        ea = 16'h0400; eb = 16'hFC00; ec = 16'h0000;
`else
        ea = 16'h0000; eb = 16'h1FFC; ec = 16'hE000;
`endif
        ctrl_ready = 1'b1;
        ch_log.delete();
        f0 = cs_frames;
        s0 = sclk_total;
`ifdef FOC_FRONTEND_CALC_C_EN
        start_frame(16'h1234, 12'h900, 12'h700, 12'h000, 0);
`else
        start_frame(16'h1234, 12'h800, 12'hFFF, 12'h000, 0);
`endif
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL frame_early_valid: got %b want 0", valid_out); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL frame_busy: got %b want 1", busy); end
        n_vec++; if (curr_b !== 16'h0) begin n_err++; $display("FAIL frame_b_premature: got %h want 0", curr_b); end
        @(negedge clk);
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL frame_valid: got %b want 1", valid_out); end
        n_vec++; if (angle_out !== 16'h1234) begin n_err++; $display("FAIL frame_angle: got %h want 1234", angle_out); end
        n_vec++; if (curr_a !== ea) begin n_err++; $display("FAIL frame_a: got %h want %h", curr_a, ea); end
        n_vec++; if (curr_b !== eb) begin n_err++; $display("FAIL frame_b: got %h want %h", curr_b, eb); end
        n_vec++; if (curr_c !== ec) begin n_err++; $display("FAIL frame_c: got %h want %h", curr_c, ec); end
        @(negedge clk);
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL frame_drop: got %b want 0", valid_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL frame_idle: got %b want 0", busy); end
        n_vec++; if (cs_frames - f0 !== NCH) begin n_err++; $display("FAIL frame_cs_count: got %0d want %0d", cs_frames - f0, NCH); end
        n_vec++; if (sclk_total - s0 !== 16 * NCH) begin n_err++; $display("FAIL frame_sclk_count: got %0d want %0d", sclk_total - s0, 16 * NCH); end
        n_vec++; if (ch_log.size() !== NCH) begin n_err++; $display("FAIL frame_mosi_count: got %0d want %0d", ch_log.size(), NCH); end
        for (int i = 0; i < ch_log.size(); i++) begin
            n_vec++; if (ch_log[i] !== i) begin n_err++; $display("FAIL frame_mosi_ch%0d: got %0d want %0d", i, ch_log[i], i); end
        end
    endtask

    task automatic test_backpressure;
        logic [79:0] exp_v;
        logic [15:0] ec;
`ifdef FOC_FRONTEND_CALC_C_EN
        ec = 16'h0000;
`else
        ec = 16'h0AF0;
`endif
        exp_v = {16'hBEEF, 16'h0004, 16'hFFFC, ec, 16'h0001};
        ctrl_ready = 1'b0;
        start_frame(16'hBEEF, 12'h801, 12'h7FF, 12'hABC, 0);
        @(negedge clk);
        n_vec++;
        if ({angle_out, curr_a, curr_b, curr_c, 15'h0, valid_out} !== exp_v) begin
            n_err++; $display("FAIL bp_first: got %h want %h", {angle_out, curr_a, curr_b, curr_c, 15'h0, valid_out}, exp_v);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_vec++;
            if ({angle_out, curr_a, curr_b, curr_c, 15'h0, valid_out} !== exp_v) begin
                n_err++; $display("FAIL bp_hold_%0d: got %h want %h", i, {angle_out, curr_a, curr_b, curr_c, 15'h0, valid_out}, exp_v);
            end
        end
        ctrl_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", valid_out); end
        n_vec++; if (curr_a !== 16'h0004) begin n_err++; $display("FAIL bp_after_a: got %h want 0004", curr_a); end
    endtask

    task automatic test_overrun;
        logic [15:0] ea, eb, ec;
`ifdef FOC_FRONTEND_CALC_C_EN
        ea = 16'h0000; eb = 16'h1FFC; ec = 16'hE004;
`else
        ea = 16'h0000; eb = 16'h1FFC; ec = 16'hE000;
`endif
        ctrl_ready = 1'b1;
        start_frame(16'h0F0F, 12'h800, 12'hFFF, 12'h000, 3);
        n_vec++; if (overrun_cnt !== 8'd3) begin n_err++; $display("FAIL ovr_shift: got %0d want 3", overrun_cnt); end
        @(negedge clk);
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", valid_out); end
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        n_vec++; if (overrun_cnt !== 8'd4) begin n_err++; $display("FAIL ovr_handshake: got %0d want 4", overrun_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_not_started: got %b want 0", busy); end
        n_vec++; if (angle_out !== 16'h0F0F) begin n_err++; $display("FAIL ovr_angle: got %h want 0f0f", angle_out); end
        n_vec++;
        if ({curr_a, curr_b, curr_c} !== {ea, eb, ec}) begin
            n_err++; $display("FAIL ovr_data: got %h want %h", {curr_a, curr_b, curr_c}, {ea, eb, ec});
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            trigger = 1'b1;
        end
        @(negedge clk);
        trigger = 1'b0;
        repeat (2 * LAT + 10) @(negedge clk);
        n_vec++; if (overrun_cnt !== 8'd255) begin n_err++; $display("FAIL ovr_saturate: got %0d want 255", overrun_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_settle: got %b want 0", busy); end
    endtask

    task automatic test_midframe_reset;
        int vhits;
        logic [15:0] ec;
`ifdef FOC_FRONTEND_CALC_C_EN
        ec = 16'h0004;
`else
        ec = 16'h0000;
`endif
        ctrl_ready = 1'b1;
        @(negedge clk);
        angle_in = 16'h5555;
        trigger  = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            trigger = 1'b0;
        end
        n_vec++; if ({busy, adc_csn} !== 2'b10) begin n_err++; $display("FAIL mid_pre: got %b want 10", {busy, adc_csn}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (adc_csn !== 1'b1) begin n_err++; $display("FAIL mid_csn: got %b want 1", adc_csn); end
        n_vec++; if (adc_sclk !== 1'b0) begin n_err++; $display("FAIL mid_sclk: got %b want 0", adc_sclk); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_vec++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL mid_overrun: got %0d want 0", overrun_cnt); end
        vhits = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1) vhits++;
        end
        n_vec++; if (vhits !== 0) begin n_err++; $display("FAIL mid_no_frame: got %0d valid cycles want 0", vhits); end
        start_frame(16'h4321, 12'h000, 12'hFFF, 12'h800, 0);
        @(negedge clk);
        n_vec++;
        if ({valid_out, angle_out, curr_a, curr_b, curr_c} !== {1'b1, 16'h4321, 16'hE000, 16'h1FFC, ec}) begin
            n_err++; $display("FAIL mid_new_frame: got %h want %h", {valid_out, angle_out, curr_a, curr_b, curr_c},
                              {1'b1, 16'h4321, 16'hE000, 16'h1FFC, ec});
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        trigger    = 1'b0;
        angle_in   = 16'h0;
        ctrl_ready = 1'b0;
        for (int i = 0; i < 4; i++) adc_raw[i] = 12'h800;
        test_reset;
        test_frame;
        test_backpressure;
        test_overrun;
        test_midframe_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
